fft_link_host: RTL
==================

// Module: fft_link_host
// PURPOSE
//  Host-side partner of the 8-point FFT tile. Takes an 8-sample frame over valid/ready and plays it onto the
//  tile's sample bus on the tile's fixed 4-cycle slot schedule (cnt 0,4,..,28). Mirrors the tile's 8-bit frame
//  counter, captures the 8 magnitude bins the tile strobes out one-hot (cnt 100..128) and returns them over valid/ready.
//  Owns tile reset/enable so both counters stay locked.
// PARAMETERS
//  W          8    sample/bin width
//  RST_CYC    2    cycles dut_rst_n held low after rst
//  CAP_OFS    2    capture offset into each 4-cycle result slot
// PORTS
//  clk        in   1  clock, single domain
//  rst        in   1  reset, asynchronous, active-high
//  s_valid    in   1  sample in valid
//  s_ready    out  1  sample in ready
//  s_data     in   W  sample (unsigned)
//  m_valid    out  1  bin out valid
//  m_ready    in   1  bin out ready
//  m_bin      out  3  bin index 0..7
//  m_data     out  W  bin magnitude
//  dut_rst_n  out  1  tile reset, active-low
//  dut_ena    out  1  tile enable
//  dut_ui     out  W  tile sample bus
//  dut_uo     in   W  tile magnitude bus
//  dut_uio    in   8  tile one-hot bin strobe
//  link_err   out  1  sticky strobe-mismatch flag
// BEHAVIOUR
//  Reset: state=DUT_RST, cnt=0, wr_cnt=0, rd_ptr=0, res_full=0, link_err=0. Outputs: dut_rst_n=0, dut_ena=0,
//   dut_ui=0, s_ready=0, m_valid=0. A mid-frame rst aborts everything and re-runs DUT_RST.
//  DUT_RST: dut_rst_n=0, dut_ena=0 for RST_CYC cycles, then RUN with cnt=0. dut_ena stays low throughout DUT_RST
//   (the tile ignores reset while enabled).
//  RUN: cnt increments (8-bit wrap 255->0) on every edge where dut_ena=1. dut_ena=0 only when cnt==0 and
//   !(wr_cnt==8 && !res_full) (PARK). Both counters then freeze at 0.
//  Sample buffer (8xW):
//   - s_ready = (wr_cnt<8) in RUN.
//   - Handshake writes buf[wr_cnt] and increments wr_cnt.
//   - dut_ui = buf[cnt[4:2]] when cnt<32, else 0.
//   - wr_cnt clears to 0 on the edge cnt 31->32.
//   - Sample k is therefore stable across the tile's sampling edge at cnt==4k.
//  Capture: on the edge where cnt==100+4j+CAP_OFS (j=0..7):
//   - res[j] <= dut_uo.
//   - If dut_uio != (1<<j), set link_err.
//   - At j=7, res_full <= 1.
//   - At cnt==132+CAP_OFS, dut_uio must be 0, else set link_err.
//  Output: m_valid = res_full, m_bin = rd_ptr, m_data = res[rd_ptr].
//   - Each handshake increments rd_ptr.
//   - Handshake at rd_ptr==7 clears res_full and rd_ptr.
//  Boundaries:
//   - The PARK rule guarantees capture never overwrites undrained results.
//   - Samples for frame n+1 are accepted from cnt 32 of frame n onward.
//   - m_valid must hold stable until ready.
//   - link_err clears only on rst.
//  dut_ena/dut_ui are decoded from registered state only; no combinational path from s_* or m_* inputs.
// STRUCTURE
//  fft_link_pkg: SLOT=4, N=8, TX_END=32, RES_BASE=100, RES_CLR=132, state enum {DUT_RST, RUN}.
//  Sub-module fft_link_frame_buf: 8xW register file with write pointer/count, read mux; used for both buffers.
// TESTING (bench includes a cycle-accurate tile model)
//  1 rst pulse -> dut_rst_n=0, dut_ena=0 for 2 clk; then s_ready=1, m_valid=0, link_err=0, cnt=0.
//  2 push 10,20,..,80 -> dut_ena rises after 8th; dut_ui=10 at cnt0-3, 20 at 4-7, .., 80 at 28-31, 0 at 32.
//  3 tile drives uio=1<<j, uo=0xA0+j from cnt 100+4j; m_ready=1 -> bins 0..7 with data A0..A7 in order,
//    link_err=0.
//  4 m_ready=0 through cnt 255, next frame buffered -> dut_ena=0 at cnt 0; release m_ready -> 8 bins drain, then
//    frame resumes.
//  5 tile drives uio=0x04 in slot 1 -> link_err=1 and stays 1; m_data for bin 1 is still captured.
//  6 rst asserted at cnt 50 -> outputs at reset values immediately; DUT_RST re-sequenced; new frame runs clean.

Source files
------------

// File: rtl/fft_link_pkg.sv
// fft_link_pkg: shared schedule constants and state type for the FFT tile host link
package fft_link_pkg;
  localparam int SLOT = 4;
  localparam int N = 8;
  localparam int TX_END = 32;
  localparam int RES_BASE = 100;
  localparam int RES_CLR = 132;
  typedef enum logic {DUT_RST, RUN} state_e;
endpackage

// File: rtl/fft_link_frame_buf.sv
// fft_link_frame_buf: 8-entry register file filled in order, with fill count and random read
module fft_link_frame_buf
  import fft_link_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         we_i,
  input  logic [W-1:0] wdata_i,
  input  logic [2:0]   raddr_i,
  output logic [W-1:0] rdata_o,
  output logic [3:0]   cnt_o
);
  logic [W-1:0] mem_q [N];
  logic [3:0]   cnt_q, cnt_d;
  logic         wr;
  always_comb begin
    wr = we_i && cnt_q < 4'(N);
    cnt_d = clr_i ? 4'd0 : cnt_q + 4'(wr);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (wr) mem_q[cnt_q[2:0]] <= wdata_i;
    end
  end
  assign rdata_o = mem_q[raddr_i];
  assign cnt_o = cnt_q;
endmodule

// File: rtl/fft_link_host.sv
// fft_link_host: feeds 8-sample frames to the FFT tile on its slot schedule and returns its 8 magnitude bins
module fft_link_host
  import fft_link_pkg::*;
#(
  parameter int W = 8,
  parameter int RST_CYC = 2,
  parameter int CAP_OFS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [2:0]   m_bin,
  output logic [W-1:0] m_data,
  output logic         dut_rst_n,
  output logic         dut_ena,
  output logic [W-1:0] dut_ui,
  input  logic [W-1:0] dut_uo,
  input  logic [7:0]   dut_uio,
  output logic         link_err
);
  state_e       state_q, state_d;
  logic [7:0]   rcnt_q, rcnt_d, cnt_q, cnt_d, off;
  logic [2:0]   rd_ptr_q, rd_ptr_d, j;
  logic         err_q, err_d, run, park, res_full, s_fire, m_fire, cap, tx_clr, res_clr;
  logic [3:0]   wr_cnt, res_cnt;
  logic [W-1:0] smp;
  always_comb begin
    run = state_q == RUN;
    res_full = res_cnt == 4'(N);
    park = cnt_q == 8'd0 && !(wr_cnt == 4'(N) && !res_full);
    dut_rst_n = run;
    dut_ena = run && !park;
    dut_ui = run && cnt_q < 8'(TX_END) ? smp : '0;
    s_ready = run && wr_cnt < 4'(N);
    s_fire = s_valid && s_ready;
    m_valid = res_full;
    m_bin = rd_ptr_q;
    m_fire = m_valid && m_ready;
    off = cnt_q - 8'(RES_BASE);
    j = 3'(off / 8'(SLOT));
    cap = run && off < 8'(N * SLOT) && (off % 8'(SLOT)) == 8'(CAP_OFS);
    tx_clr = dut_ena && cnt_q == 8'(TX_END - 1);
    res_clr = m_fire && rd_ptr_q == 3'(N - 1);
    cnt_d = dut_ena ? cnt_q + 8'd1 : cnt_q;
    rd_ptr_d = m_fire ? rd_ptr_q + 3'd1 : rd_ptr_q;
    state_d = !run && rcnt_q == 8'(RST_CYC - 1) ? RUN : state_q;
    rcnt_d = run ? rcnt_q : rcnt_q + 8'd1;
    // The strobe must be exactly one-hot on every capture and fully released after the last slot
    err_d = err_q || (cap && dut_uio != (8'd1 << j))
                  || (run && cnt_q == 8'(RES_CLR + CAP_OFS) && dut_uio != 8'd0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DUT_RST;
      rcnt_q <= '0;
      cnt_q <= '0;
      rd_ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q <= rcnt_d;
      cnt_q <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      err_q <= err_d;
    end
  end
  assign link_err = err_q;
  fft_link_frame_buf #(.W(W)) u_tx (
    .clk(clk), .rst(rst), .clr_i(tx_clr), .we_i(s_fire), .wdata_i(s_data),
    .raddr_i(cnt_q[4:2]), .rdata_o(smp), .cnt_o(wr_cnt)
  );
  fft_link_frame_buf #(.W(W)) u_res (
    .clk(clk), .rst(rst), .clr_i(res_clr), .we_i(cap), .wdata_i(dut_uo),
    .raddr_i(rd_ptr_q), .rdata_o(m_data), .cnt_o(res_cnt)
  );
endmodule
